// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: execute-stage and divider-side signals of the HI/LO multiply/divide controller.
// The slave modport is the controller; the master modport is its environment (execute stage plus divider).
interface mdu_ctrl_if;
  logic        flush_i;
  logic        stall_i;
  logic        op_valid_i;
  logic [3:0]  mduop_i;
  logic [31:0] opr1_i;
  logic [31:0] opr2_i;
  logic        div_start_o;
  logic        div_signed_o;
  logic [31:0] div_opr1_o;
  logic [31:0] div_opr2_o;
  logic        div_cancel_o;
  logic        div_done_i;
  logic [31:0] div_q_i;
  logic [31:0] div_r_i;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        mdu_is_active;
  logic        mdu_div_active;
  logic        stallreq_o;

  modport slave (
    input  flush_i, stall_i, op_valid_i, mduop_i, opr1_i, opr2_i,
    input  div_done_i, div_q_i, div_r_i,
    output div_start_o, div_signed_o, div_opr1_o, div_opr2_o, div_cancel_o,
    output hi_o, lo_o, mdu_is_active, mdu_div_active, stallreq_o
  );

  modport master (
    output flush_i, stall_i, op_valid_i, mduop_i, opr1_i, opr2_i,
    output div_done_i, div_q_i, div_r_i,
    input  div_start_o, div_signed_o, div_opr1_o, div_opr2_o, div_cancel_o,
    input  hi_o, lo_o, mdu_is_active, mdu_div_active, stallreq_o
  );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: HI/LO controller with a 2-stage 32x32 multiplier and an external iterative divider.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu; otherwise opcodes 7-10 decode as none.
module mdu_ctrl (
  input  logic      clk,
  input  logic      rst,
  mdu_ctrl_if.slave bus
);

`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_MUL1, S_MUL2, S_DIV} state_e;
  typedef enum logic [3:0] {
    OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO,
    OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, OP_MFHI, OP_MFLO
  } op_e;
  typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} acc_e;

  state_e           state_q, state_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic             mul_neg_q, mul_neg_d;
  acc_e             acc_q, acc_d;
  logic [3:0][31:0] pp_q, pp_d;
  logic [31:0]      div_opr1_q, div_opr1_d, div_opr2_q, div_opr2_d;
  logic             div_signed_q, div_signed_d;
  logic             div_start_q, div_start_d;

  logic        op_known, op_mul, op_div, mul_signed;
  acc_e        acc_sel;
  logic        busy, stallreq, accept;
  logic [63:0] prod_mag, prod, hilo_new;

  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? -v : v;
  endfunction

  // NOTE: every always_comb output gets a default before the case so no path can infer a latch.
  always_comb begin
    op_known   = 1'b0;
    op_mul     = 1'b0;
    op_div     = 1'b0;
    mul_signed = 1'b0;
    acc_sel    = ACC_NONE;
    case (bus.mduop_i)
      OP_MULT:  begin op_known = 1'b1; op_mul = 1'b1; mul_signed = 1'b1; end
      OP_MULTU: begin op_known = 1'b1; op_mul = 1'b1; end
      OP_DIV, OP_DIVU: begin op_known = 1'b1; op_div = 1'b1; end
      OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO: op_known = 1'b1;
      OP_MADD:  begin op_known = MADD_EN; op_mul = MADD_EN; mul_signed = 1'b1; acc_sel = ACC_ADD; end
      OP_MADDU: begin op_known = MADD_EN; op_mul = MADD_EN; acc_sel = ACC_ADD; end
      OP_MSUB:  begin op_known = MADD_EN; op_mul = MADD_EN; mul_signed = 1'b1; acc_sel = ACC_SUB; end
      OP_MSUBU: begin op_known = MADD_EN; op_mul = MADD_EN; acc_sel = ACC_SUB; end
      default: ;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign stallreq = bus.op_valid_i & busy & op_known;
  assign accept   = bus.op_valid_i & ~bus.stall_i & ~bus.flush_i & ~stallreq & ~busy;

  // Signed products run as unsigned magnitudes with the sign applied after the final sum.
  assign prod_mag = {32'd0, pp_q[0]} + {16'd0, pp_q[1], 16'd0}
                  + {16'd0, pp_q[2], 16'd0} + {pp_q[3], 32'd0};
  assign prod     = mul_neg_q ? -prod_mag : prod_mag;

  always_comb begin
    hilo_new = prod;
    case (acc_q)
      ACC_ADD: hilo_new = {hi_q, lo_q} + prod;
      ACC_SUB: hilo_new = {hi_q, lo_q} - prod;
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    mul_neg_d    = mul_neg_q;
    acc_d        = acc_q;
    pp_d         = pp_q;
    div_opr1_d   = div_opr1_q;
    div_opr2_d   = div_opr2_q;
    div_signed_d = div_signed_q;
    div_start_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op_mul) begin
            mul_a_d   = magnitude(bus.opr1_i, mul_signed);
            mul_b_d   = magnitude(bus.opr2_i, mul_signed);
            mul_neg_d = mul_signed & (bus.opr1_i[31] ^ bus.opr2_i[31]);
            acc_d     = acc_sel;
            state_d   = S_MUL1;
          end else if (op_div && bus.opr2_i != 32'd0) begin
            div_opr1_d   = bus.opr1_i;
            div_opr2_d   = bus.opr2_i;
            div_signed_d = (bus.mduop_i == OP_DIV);
            div_start_d  = 1'b1;
            state_d      = S_DIV;
          end else if (bus.mduop_i == OP_MTHI) begin
            hi_d = bus.opr1_i;
          end else if (bus.mduop_i == OP_MTLO) begin
            lo_d = bus.opr1_i;
          end
        end
      end
      S_MUL1: begin
        if (bus.flush_i) begin
          state_d = S_IDLE;
        end else begin
          pp_d[0] = {16'd0, mul_a_q[15:0]}  * {16'd0, mul_b_q[15:0]};
          pp_d[1] = {16'd0, mul_a_q[15:0]}  * {16'd0, mul_b_q[31:16]};
          pp_d[2] = {16'd0, mul_a_q[31:16]} * {16'd0, mul_b_q[15:0]};
          pp_d[3] = {16'd0, mul_a_q[31:16]} * {16'd0, mul_b_q[31:16]};
          state_d = S_MUL2;
        end
      end
      S_MUL2: begin
        state_d = S_IDLE;
        if (!bus.flush_i) begin
          {hi_d, lo_d} = hilo_new;
        end
      end
      S_DIV: begin
        if (bus.flush_i) begin
          state_d = S_IDLE;
        end else if (bus.div_done_i) begin
          hi_d    = bus.div_r_i;
          lo_d    = bus.div_q_i;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples the pre-edge values of its inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      hi_q         <= '0;
      lo_q         <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_neg_q    <= 1'b0;
      acc_q        <= ACC_NONE;
      pp_q         <= '0;
      div_opr1_q   <= '0;
      div_opr2_q   <= '0;
      div_signed_q <= 1'b0;
      div_start_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      mul_neg_q    <= mul_neg_d;
      acc_q        <= acc_d;
      pp_q         <= pp_d;
      div_opr1_q   <= div_opr1_d;
      div_opr2_q   <= div_opr2_d;
      div_signed_q <= div_signed_d;
      div_start_q  <= div_start_d;
    end
  end

  assign bus.hi_o           = hi_q;
  assign bus.lo_o           = lo_q;
  assign bus.div_start_o    = div_start_q;
  assign bus.div_signed_o   = div_signed_q;
  assign bus.div_opr1_o     = div_opr1_q;
  assign bus.div_opr2_o     = div_opr2_q;
  // A reset in DIV resets the divider directly, so the abort pulse is suppressed then.
  assign bus.div_cancel_o   = (state_q == S_DIV) & bus.flush_i & ~rst;
  assign bus.mdu_is_active  = busy;
  assign bus.mdu_div_active = (state_q == S_DIV);
  assign bus.stallreq_o     = stallreq;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: table-driven vectors, hand-written divide/reset sequences and a randomized run
// against an arithmetic reference model of the HI/LO unit; the bench also plays the divider.
module tb_mdu_ctrl;
  logic clk = 1'b0;
  logic rst;
  mdu_ctrl_if bus ();

  mdu_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

`ifdef MDU_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        v;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        st, fl, dn;
    logic [31:0] q, r;
    logic [31:0] hi, lo;
    logic        act, dact, sreq, start, cancel;
  } vec_t;

  localparam int NV = 34;
  vec_t tbl[NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic st, input logic fl, input logic dn,
                       input logic [31:0] q, input logic [31:0] rr);
    rst            = r;
    bus.op_valid_i = v;
    bus.mduop_i    = op;
    bus.opr1_i     = a;
    bus.opr2_i     = b;
    bus.stall_i    = st;
    bus.flush_i    = fl;
    bus.div_done_i = dn;
    bus.div_q_i    = q;
    bus.div_r_i    = rr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t row(input logic v, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic st, input logic fl, input logic dn,
                               input logic [31:0] q, input logic [31:0] r,
                               input logic [31:0] hi, input logic [31:0] lo,
                               input logic act, input logic dact, input logic sreq,
                               input logic start, input logic cancel);
    vec_t t;
    t.v = v; t.op = op; t.a = a; t.b = b; t.st = st; t.fl = fl; t.dn = dn; t.q = q; t.r = r;
    t.hi = hi; t.lo = lo; t.act = act; t.dact = dact; t.sreq = sreq; t.start = start;
    t.cancel = cancel;
    return t;
  endfunction

  // ---------------- reference model ----------------
  typedef enum {P_IDLE, P_MUL, P_DIV} phase_e;
  phase_e      m_phase;
  int          m_left;
  logic        m_first;
  logic [3:0]  m_op;
  logic [31:0] m_a, m_b, m_hi, m_lo, m_da, m_db;
  logic        m_dsig;

  function automatic bit known_op(input logic [3:0] op);
    return (op >= 4'd1 && op <= 4'd6) || op == 4'd11 || op == 4'd12 ||
           (MADD && op >= 4'd7 && op <= 4'd10);
  endfunction

  function automatic logic [63:0] product(input logic [31:0] a, input logic [31:0] b,
                                          input bit sgn);
    longint sa, sb;
    longint unsigned ua, ub;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_left = 0; m_first = 1'b0; m_op = '0;
    m_a = '0; m_b = '0; m_hi = '0; m_lo = '0; m_da = '0; m_db = '0; m_dsig = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic v, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic st, input logic fl, input logic dn,
                            input logic [31:0] q, input logic [31:0] rr);
    logic [63:0] p, acc;
    if (r) begin
      model_reset();
      return;
    end
    case (m_phase)
      P_MUL: begin
        if (fl) m_phase = P_IDLE;
        else if (m_left > 1) m_left--;
        else begin
          p   = product(m_a, m_b, m_op == 4'd1 || m_op == 4'd7 || m_op == 4'd9);
          acc = {m_hi, m_lo};
          if (m_op == 4'd7 || m_op == 4'd8) acc = acc + p;
          else if (m_op == 4'd9 || m_op == 4'd10) acc = acc - p;
          else acc = p;
          {m_hi, m_lo} = acc;
          m_phase = P_IDLE;
        end
      end
      P_DIV: begin
        m_first = 1'b0;
        if (fl) m_phase = P_IDLE;
        else if (dn) begin
          m_hi = rr; m_lo = q; m_phase = P_IDLE;
        end
      end
      default: begin
        if (v && !st && !fl) begin
          if (op == 4'd5) m_hi = a;
          else if (op == 4'd6) m_lo = a;
          else if (op == 4'd1 || op == 4'd2 || (MADD && op >= 4'd7 && op <= 4'd10)) begin
            m_op = op; m_a = a; m_b = b; m_left = 2; m_phase = P_MUL;
          end else if ((op == 4'd3 || op == 4'd4) && b != 32'd0) begin
            m_da = a; m_db = b; m_dsig = (op == 4'd3); m_first = 1'b1; m_phase = P_DIV;
          end
        end
      end
    endcase
  endtask

  function automatic logic [31:0] pick_opr();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int start_cnt;
    drive(1'b1, 1'b0, 4'd0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    tick();

    tbl[0]  = row(1, 5, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = row(1, 6, 32'h9ABC_DEF0, 0, 0, 0, 0, 0, 0, 32'h1234_5678, 0, 0, 0, 0, 0, 0);
    tbl[2]  = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 0, 0, 0);
    tbl[3]  = row(1, 1, 32'hFFFF_FFFF, 2, 0, 0, 0, 0, 0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 0, 0, 0);
    tbl[4]  = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234_5678, 32'h9ABC_DEF0, 1, 0, 0, 0, 0);
    tbl[5]  = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234_5678, 32'h9ABC_DEF0, 1, 0, 0, 0, 0);
    tbl[6]  = row(1, 2, 32'hFFFF_FFFF, 2, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0, 0, 0, 0);
    tbl[7]  = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 0, 0, 0, 0);
    tbl[8]  = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 0, 0, 0, 0);
    tbl[9]  = row(1, 5, 32'hDEAD_BEEF, 0, 1, 0, 0, 0, 0, 32'd1, 32'hFFFF_FFFE, 0, 0, 0, 0, 0);
    tbl[10] = row(1, 5, 0, 0, 0, 1, 0, 0, 0, 32'd1, 32'hFFFF_FFFE, 0, 0, 0, 0, 0);
    tbl[11] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd1, 32'hFFFF_FFFE, 0, 0, 0, 0, 0);
    tbl[12] = row(1, 1, 3, 5, 0, 0, 0, 0, 0, 32'd1, 32'hFFFF_FFFE, 0, 0, 0, 0, 0);
    tbl[13] = row(1, 12, 0, 0, 0, 0, 0, 0, 0, 32'd1, 32'hFFFF_FFFE, 1, 0, 1, 0, 0);
    tbl[14] = row(0, 0, 0, 0, 0, 1, 0, 0, 0, 32'd1, 32'hFFFF_FFFE, 1, 0, 0, 0, 0);
    tbl[15] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd1, 32'hFFFF_FFFE, 0, 0, 0, 0, 0);
    tbl[16] = row(1, 4, 55, 0, 0, 0, 0, 0, 0, 32'd1, 32'hFFFF_FFFE, 0, 0, 0, 0, 0);
    tbl[17] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd1, 32'hFFFF_FFFE, 0, 0, 0, 0, 0);
    tbl[18] = row(1, 3, 100, 7, 0, 0, 0, 0, 0, 32'd1, 32'hFFFF_FFFE, 0, 0, 0, 0, 0);
    tbl[19] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd1, 32'hFFFF_FFFE, 1, 1, 0, 1, 0);
    tbl[20] = row(0, 0, 0, 0, 0, 1, 1, 32'hAAAA, 32'hBBBB, 32'd1, 32'hFFFF_FFFE, 1, 1, 0, 0, 1);
    tbl[21] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd1, 32'hFFFF_FFFE, 0, 0, 0, 0, 0);
    tbl[22] = row(0, 0, 0, 0, 0, 0, 1, 32'h1111, 32'h2222, 32'd1, 32'hFFFF_FFFE, 0, 0, 0, 0, 0);
    tbl[23] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd1, 32'hFFFF_FFFE, 0, 0, 0, 0, 0);
    tbl[24] = row(1, 2, 10, 10, 0, 0, 0, 0, 0, 32'd1, 32'hFFFF_FFFE, 0, 0, 0, 0, 0);
    tbl[25] = row(1, 11, 0, 0, 1, 0, 0, 0, 0, 32'd1, 32'hFFFF_FFFE, 1, 0, 1, 0, 0);
    tbl[26] = row(0, 0, 0, 0, 1, 0, 0, 0, 0, 32'd1, 32'hFFFF_FFFE, 1, 0, 0, 0, 0);
    tbl[27] = row(0, 0, 0, 0, 1, 0, 0, 0, 0, 32'd0, 32'd100, 0, 0, 0, 0, 0);
    tbl[28] = row(1, 5, 0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd100, 0, 0, 0, 0, 0);
    tbl[29] = row(1, 6, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 32'd0, 32'd100, 0, 0, 0, 0, 0);
    tbl[30] = row(1, 8, 1, 1, 0, 0, 0, 0, 0, 32'd0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    tbl[31] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 32'hFFFF_FFFF, MADD, 0, 0, 0, 0);
    tbl[32] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 32'hFFFF_FFFF, MADD, 0, 0, 0, 0);
    tbl[33] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, MADD ? 32'd1 : 32'd0,
                  MADD ? 32'd0 : 32'hFFFF_FFFF, 0, 0, 0, 0, 0);

    check("rst.div_opr1", bus.div_opr1_o, 64'd0);
    check("rst.div_opr2", bus.div_opr2_o, 64'd0);
    check("rst.div_signed", bus.div_signed_o, 64'd0);

    for (int i = 0; i < NV; i++) begin
      drive(1'b0, tbl[i].v, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].st, tbl[i].fl, tbl[i].dn,
            tbl[i].q, tbl[i].r);
      #1;
      check($sformatf("vec%0d.hi", i), bus.hi_o, tbl[i].hi);
      check($sformatf("vec%0d.lo", i), bus.lo_o, tbl[i].lo);
      check($sformatf("vec%0d.active", i), bus.mdu_is_active, tbl[i].act);
      check($sformatf("vec%0d.div_active", i), bus.mdu_div_active, tbl[i].dact);
      check($sformatf("vec%0d.stallreq", i), bus.stallreq_o, tbl[i].sreq);
      check($sformatf("vec%0d.div_start", i), bus.div_start_o, tbl[i].start);
      check($sformatf("vec%0d.div_cancel", i), bus.div_cancel_o, tbl[i].cancel);
      tick();
    end

    // div -7 / 2, divider answers in its 32nd cycle while mflo waits behind it.
    drive(1'b0, 1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    check("div7.accept_idle", bus.mdu_is_active, 64'd0);
    tick();
    start_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b1, 4'd12, '0, '0, 1'b0, 1'b0, i == 31, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      #1;
      if (bus.div_start_o) start_cnt++;
      check($sformatf("div7.c%0d.stallreq", i), bus.stallreq_o, 64'd1);
      check($sformatf("div7.c%0d.div_active", i), bus.mdu_div_active, 64'd1);
      check($sformatf("div7.c%0d.opr1", i), bus.div_opr1_o, 64'hFFFF_FFF9);
      check($sformatf("div7.c%0d.opr2", i), bus.div_opr2_o, 64'd2);
      check($sformatf("div7.c%0d.signed", i), bus.div_signed_o, 64'd1);
      tick();
    end
    check("div7.start_pulses", 64'(start_cnt), 64'd1);
    drive(1'b0, 1'b1, 4'd12, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    check("div7.done.stallreq", bus.stallreq_o, 64'd0);
    check("div7.done.div_active", bus.mdu_div_active, 64'd0);
    check("div7.done.hi", bus.hi_o, 64'hFFFF_FFFF);
    check("div7.done.lo", bus.lo_o, 64'hFFFF_FFFD);
    tick();

    // Reset in DIV with flush and an mthi present: no cancel pulse, everything cleared.
    drive(1'b0, 1'b1, 4'd4, 32'd9, 32'd3, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    drive(1'b0, 1'b0, 4'd0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    check("rstdiv.div_active", bus.mdu_div_active, 64'd1);
    check("rstdiv.unsigned", bus.div_signed_o, 64'd0);
    tick();
    drive(1'b1, 1'b1, 4'd5, 32'h7777_7777, '0, 1'b0, 1'b1, 1'b0, '0, '0);
    #1;
    check("rstdiv.cancel", bus.div_cancel_o, 64'd0);
    tick();
    drive(1'b0, 1'b0, 4'd0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    check("rstdiv.active", bus.mdu_is_active, 64'd0);
    check("rstdiv.div_start", bus.div_start_o, 64'd0);
    check("rstdiv.hi", bus.hi_o, 64'd0);
    check("rstdiv.lo", bus.lo_o, 64'd0);
    check("rstdiv.opr1", bus.div_opr1_o, 64'd0);
    check("rstdiv.opr2", bus.div_opr2_o, 64'd0);

    // Randomized run against the reference model, starting from the reset state.
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      logic r, v, st, fl, dn;
      logic [3:0] op;
      logic [31:0] a, b, q, rr;
      r  = ($urandom_range(0, 149) == 0);
      v  = ($urandom_range(0, 3) != 0);
      op = 4'($urandom_range(0, 15));
      a  = pick_opr();
      b  = pick_opr();
      st = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 11) == 0);
      dn = ($urandom_range(0, 5) == 0);
      q  = $urandom;
      rr = $urandom;
      drive(r, v, op, a, b, st, fl, dn, q, rr);
      #1;
      check("rnd.hi", bus.hi_o, m_hi);
      check("rnd.lo", bus.lo_o, m_lo);
      check("rnd.active", bus.mdu_is_active, m_phase != P_IDLE);
      check("rnd.div_active", bus.mdu_div_active, m_phase == P_DIV);
      check("rnd.stallreq", bus.stallreq_o, v && m_phase != P_IDLE && known_op(op));
      check("rnd.div_start", bus.div_start_o, m_phase == P_DIV && m_first);
      check("rnd.div_cancel", bus.div_cancel_o, m_phase == P_DIV && fl && !r);
      check("rnd.div_opr1", bus.div_opr1_o, m_da);
      check("rnd.div_opr2", bus.div_opr2_o, m_db);
      check("rnd.div_signed", bus.div_signed_o, m_dsig);
      model_step(r, v, op, a, b, st, fl, dn, q, rr);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 Port rst, input, 1: reset, synchronous, active-high.
REQ-003 Port flush_i, input, 1: pipeline flush from controller; cancels in-flight op.
REQ-004 Port stall_i, input, 1: execute-stage stall; no new op accepted while high.
REQ-005 Port op_valid_i, input, 1: execute stage presents an MDU op.
REQ-006 Port mduop_i, input, 4: opcode. 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu, 11 mfhi, 12 mflo; 13-15 treated as none.
REQ-007 Port opr1_i / opr2_i, input, 32 each: rs / rt operands.
REQ-008 Port div_start_o, output, 1: one-cycle start pulse to iterative divider.
REQ-009 Port div_signed_o, output, 1: signed-divide select, held through DIV.
REQ-010 Port div_opr1_o / div_opr2_o, output, 32 each: latched dividend / divisor, held through DIV.
REQ-011 Port div_cancel_o, output, 1: one-cycle abort pulse to divider.
REQ-012 Port div_done_i, input, 1: divider result valid.
REQ-013 Port div_q_i / div_r_i, input, 32 each: quotient / remainder.
REQ-014 Port hi_o / lo_o, output, 32 each: architectural HI/LO.
REQ-015 Port mdu_is_active, output, 1: state != IDLE.
REQ-016 Port mdu_div_active, output, 1: state == DIV.
REQ-017 Port stallreq_o, output, 1: combinational stall request to controller.

Function
REQ-018 States: IDLE, MUL1, MUL2, DIV.
REQ-019 Accept: op_valid_i & ~stall_i & ~flush_i & ~stallreq_o & state == IDLE.
REQ-020 stallreq_o = op_valid_i & mdu_is_active & (mduop_i in 1..12).
REQ-021 mthi / mtlo: HI / LO <= opr1_i at the accept edge; state stays IDLE.
REQ-022 mfhi / mflo: no state change; hi_o / lo_o hold the value read by execute.
REQ-023 mult / multu: at accept, latch operands and go IDLE->MUL1; MUL1->MUL2; MUL2->IDLE.
REQ-024 On the MUL2->IDLE edge, {HI,LO} <= 64-bit product (signed for mult, unsigned for multu). Result is visible on hi_o/lo_o 3 cycles after the accept edge.
REQ-025 Product is computed in 2 registered stages: 16-bit partial products, then sum.
REQ-026 div / divu with opr2_i != 0: latch operands and signedness, then go IDLE->DIV. div_start_o is high for exactly the first DIV cycle.
REQ-027 In DIV, on div_done_i: HI <= div_r_i, LO <= div_q_i, next state IDLE.
REQ-028 div / divu with opr2_i == 0: HI/LO unchanged, state stays IDLE, divider not started.
REQ-029 flush_i in MUL1, MUL2 or DIV: next state IDLE, HI/LO not updated. In DIV, div_cancel_o is high for that cycle.
REQ-030 flush_i and div_done_i in the same cycle: flush wins.
REQ-031 flush_i together with an op in IDLE: op ignored.
REQ-032 stall_i high while busy: the state machine continues to advance; stall_i only blocks acceptance.
REQ-033 div_done_i outside DIV: ignored.

Reset
REQ-034 rst high at a clock edge: state IDLE; HI, LO, latched operands = 0.
REQ-035 rst high at a clock edge: div_start_o, div_cancel_o, mdu_is_active, mdu_div_active = 0.
REQ-036 rst mid-DIV: go to IDLE without asserting div_cancel_o; divider is reset by the same rst.
REQ-037 rst has priority over flush_i and all ops.

Configuration
REQ-038 Macro MDU_MADD_EN defined: madd/maddu/msub/msubu follow the mult sequence; at MUL2 exit {HI,LO} <= {HI,LO} +/- 64-bit product, signedness per opcode, wrap modulo 2^64.
REQ-039 Macro MDU_MADD_EN undefined: opcodes 7-10 are treated as none (no state change, no stall, HI/LO unchanged).

Verification
REQ-040 Reset, then mthi 0x12345678 and mtlo 0x9ABCDEF0 -> next cycle hi_o = 0x12345678, lo_o = 0x9ABCDEF0.
REQ-041 mult 0xFFFFFFFF x 0x00000002 -> mdu_is_active high 2 cycles; 3 cycles after accept, hi_o = 0xFFFFFFFF, lo_o = 0xFFFFFFFE. Same operands with multu -> hi_o = 0x00000001, lo_o = 0xFFFFFFFE.
REQ-042 div -7 / 2 with div_done_i after 32 cycles -> div_start_o pulses once; mdu_div_active high until done; then lo_o = 0xFFFFFFFD, hi_o = 0xFFFFFFFF.
REQ-043 mflo while in DIV -> stallreq_o = 1 each cycle until the IDLE return; op then accepted. divu x/0 -> no div_start_o, HI/LO unchanged.
REQ-044 flush_i in the same cycle as div_done_i -> div_cancel_o = 1, HI/LO unchanged, IDLE next cycle.
REQ-045 With MDU_MADD_EN: HI:LO = 0:0xFFFFFFFF, then maddu 1 x 1 -> HI = 1, LO = 0. Without MDU_MADD_EN: same op -> HI/LO unchanged, mdu_is_active stays 0.
